uart_rx_fifo: RTL and testbench

//   Synchronous FIFO between the UART receiver and the ALU interface FSM. Buffers received

---
 rtl/uart_rx_fifo.sv | 100 ++++++++++
 tb/tb_uart_rx_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO between the UART receiver and the ALU interface FSM.
// The head-of-queue word is always presented on o_rdata, and i_rd pops it.
// Occupancy and empty/full/almost-full are taken from a dedicated count register,
// never from a pointer compare. Overflow and underflow are sticky until reset or clear.
module uart_rx_fifo #(
  parameter int NB_DATA     = 8,
  parameter int NB_ADDR     = 2,
  parameter int ALMOST_FULL = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_wr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic               i_rd,
  output logic [NB_DATA-1:0] o_rdata,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_almost_full,
  output logic [NB_ADDR:0]   o_count,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int               DEPTH     = 2 ** NB_ADDR;
  localparam logic [NB_ADDR:0] DEPTH_CNT = (NB_ADDR + 1)'(DEPTH);
  localparam logic [NB_ADDR:0] AF_CNT    = (NB_ADDR + 1)'(ALMOST_FULL);

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] rd_ptr;
  logic [NB_ADDR:0]   count;
  logic               overflow;
  logic               underflow;

  logic empty;
  logic full;
  logic do_wr;
  logic do_rd;
  logic mem_we;

  // A push is accepted when there is room, or when a pop in the same cycle frees a slot.
  // A pop is accepted whenever something is stored.
  assign empty  = (count == '0);
  assign full   = (count == DEPTH_CNT);
  assign do_wr  = i_wr & (~full | i_rd);
  assign do_rd  = i_rd & ~empty;
  assign mem_we = do_wr & ~i_reset & ~i_clear;

  // Storage write port: an accepted push stores its word at the write pointer.
  // NOTE: The storage array has no reset. The count decides which entries are valid,
  // so stale words are never exposed as data, and the array stays plain registers.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= i_wdata;
    end
  end

  // Pointers, occupancy and sticky errors. Reset takes priority over clear, and clear
  // takes priority over push and pop.
  // NOTE: All state here is assigned with <=. Every update in the block then reads the
  // pre-edge count and flags, which matches the "evaluated on current count" rule.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (i_wr && full && !i_rd) begin
        overflow <= 1'b1;
      end
      if (i_rd && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Outputs come from registers only. There is no path from an input to an output.
  assign o_rdata       = mem[rd_ptr];
  assign o_empty       = empty;
  assign o_full        = full;
  assign o_almost_full = (count >= AF_CNT);
  assign o_count       = count;
  assign o_overflow    = overflow;
  assign o_underflow   = underflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scenario tasks plus a randomized run.
// The randomized run is checked against a queue-based reference model of the FIFO.
module tb_uart_rx_fifo;

  logic       i_clk;
  logic       i_reset;
  logic       i_clear;
  logic       i_wr;
  logic [7:0] i_wdata;
  logic       i_rd;
  logic [7:0] o_rdata;
  logic       o_empty;
  logic       o_full;
  logic       o_almost_full;
  logic [2:0] o_count;
  logic       o_overflow;
  logic       o_underflow;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the stored words as a queue, plus the two sticky flags.
  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_udf;

  uart_rx_fifo dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_clear       (i_clear),
    .i_wr          (i_wr),
    .i_wdata       (i_wdata),
    .i_rd          (i_rd),
    .o_rdata       (o_rdata),
    .o_empty       (o_empty),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
    .o_count       (o_count),
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Applies one clock edge's worth of request to the queue model.
  task automatic model_step(input logic wr, input logic [7:0] wd, input logic rd,
                            input logic clr, input logic rst);
    bit was_full;
    bit was_empty;
    if (rst || clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      was_full  = (q.size() == 4);
      was_empty = (q.size() == 0);
      if (rd && was_empty) m_udf = 1'b1;
      if (wr && was_full && !rd) m_ovf = 1'b1;
      if (rd && !was_empty) void'(q.pop_front());
      if (wr && (!was_full || rd)) q.push_back(wd);
    end
  endtask

  // Drives one cycle of requests. The model is updated at the edge, and the task
  // returns 1 ns after the edge with all requests dropped.
  task automatic apply(input logic wr, input logic [7:0] wd, input logic rd,
                       input logic clr, input logic rst);
    i_wr    = wr;
    i_wdata = wd;
    i_rd    = rd;
    i_clear = clr;
    i_reset = rst;
    @(posedge i_clk);
    model_step(wr, wd, rd, clr, rst);
    #1;
    i_wr    = 1'b0;
    i_rd    = 1'b0;
    i_clear = 1'b0;
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", o_empty); end
    n_cmp++; if (o_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", o_full); end
    n_cmp++; if (o_almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b expected 0", o_almost_full); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", o_overflow); end
    n_cmp++; if (o_underflow !== 1'b0) begin n_err++; $display("FAIL reset_udf: got %b expected 0", o_underflow); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_after[2];
    exp_after[0] = 8'h0A;
    exp_after[1] = 8'h03;
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (o_empty !== 1'b0) begin n_err++; $display("FAIL basic_not_empty: got %b expected 0", o_empty); end
    n_cmp++; if (o_rdata !== 8'h05) begin n_err++; $display("FAIL basic_head_first: got %h expected 05", o_rdata); end
    apply(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (o_almost_full !== 1'b0) begin n_err++; $display("FAIL basic_afull_at2: got %b expected 0", o_almost_full); end
    apply(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (o_count !== 3'd3) begin n_err++; $display("FAIL basic_count3: got %0d expected 3", o_count); end
    n_cmp++; if (o_almost_full !== 1'b1) begin n_err++; $display("FAIL basic_afull_at3: got %b expected 1", o_almost_full); end
    n_cmp++; if (o_rdata !== 8'h05) begin n_err++; $display("FAIL basic_head: got %h expected 05", o_rdata); end
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (o_rdata !== exp_after[k]) begin n_err++; $display("FAIL basic_pop%0d: got %h expected %h", k, o_rdata, exp_after[k]); end
    end
    apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL basic_empty: got %b expected 1", o_empty); end
    n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL basic_count0: got %0d expected 0", o_count); end
    n_cmp++; if ({o_overflow, o_underflow} !== 2'b00) begin n_err++; $display("FAIL basic_flags: got %b expected 00", {o_overflow, o_underflow}); end
  endtask

  task automatic test_overflow();
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) apply(1'b1, 8'h11 + 8'(k), 1'b0, 1'b0, 1'b0);
    n_cmp++; if (o_full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b expected 1", o_full); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_not_yet: got %b expected 0", o_overflow); end
    apply(1'b1, 8'h15, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", o_overflow); end
    n_cmp++; if (o_count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d expected 4", o_count); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (o_rdata !== 8'h11 + 8'(k)) begin n_err++; $display("FAIL ovf_pop%0d: got %h expected %h", k, o_rdata, 8'h11 + 8'(k)); end
      apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL ovf_drained: got %b expected 1", o_empty); end
    n_cmp++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", o_overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_seq[4];
    exp_seq[0] = 8'h12;
    exp_seq[1] = 8'h13;
    exp_seq[2] = 8'h14;
    exp_seq[3] = 8'h20;
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) apply(1'b1, 8'h11 + 8'(k), 1'b0, 1'b0, 1'b0);
    apply(1'b1, 8'h20, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (o_count !== 3'd4) begin n_err++; $display("FAIL fullpp_count: got %0d expected 4", o_count); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL fullpp_ovf: got %b expected 0", o_overflow); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (o_rdata !== exp_seq[k]) begin n_err++; $display("FAIL fullpp_pop%0d: got %h expected %h", k, o_rdata, exp_seq[k]); end
      apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_empty_push_pop();
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (o_count !== 3'd1) begin n_err++; $display("FAIL emptypp_count: got %0d expected 1", o_count); end
    n_cmp++; if (o_rdata !== 8'h33) begin n_err++; $display("FAIL emptypp_data: got %h expected 33", o_rdata); end
    n_cmp++; if (o_underflow !== 1'b1) begin n_err++; $display("FAIL emptypp_udf: got %b expected 1", o_underflow); end
    apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (o_underflow !== 1'b1) begin n_err++; $display("FAIL emptypp_udf_sticky: got %b expected 1", o_underflow); end
  endtask

  task automatic test_back_to_back_wrap();
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 10; k++) begin
      n_cmp++; if (o_rdata !== 8'h40 + 8'(k - 1)) begin n_err++; $display("FAIL wrap_order%0d: got %h expected %h", k, o_rdata, 8'h40 + 8'(k - 1)); end
      apply(1'b1, 8'h40 + 8'(k), 1'b1, 1'b0, 1'b0);
    end
    n_cmp++; if (o_rdata !== 8'h49) begin n_err++; $display("FAIL wrap_last: got %h expected 49", o_rdata); end
    apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b expected 1", o_empty); end
    n_cmp++; if (o_underflow !== 1'b0) begin n_err++; $display("FAIL wrap_udf: got %b expected 0", o_underflow); end
  endtask

  task automatic test_clear_reset();
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) apply(1'b1, 8'h50 + 8'(k), 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({o_count, o_overflow, o_underflow} !== {3'd2, 2'b11}) begin n_err++; $display("FAIL clr_setup: got %0d/%b%b expected 2/11", o_count, o_overflow, o_underflow); end
    apply(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL clr_count: got %0d expected 0", o_count); end
    n_cmp++; if ({o_overflow, o_underflow} !== 2'b00) begin n_err++; $display("FAIL clr_flags: got %b expected 00", {o_overflow, o_underflow}); end
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL clr_not_stored: got %b expected 1", o_empty); end
    for (int k = 0; k < 3; k++) apply(1'b1, 8'h60 + 8'(k), 1'b0, 1'b0, 1'b0);
    apply(1'b1, 8'h63, 1'b1, 1'b0, 1'b1);
    n_cmp++; if ({o_count, o_empty, o_full, o_almost_full, o_overflow, o_underflow} !== {3'd0, 5'b10000}) begin
      n_err++; $display("FAIL rst_burst: got %0d/%b%b%b%b%b expected 0/10000", o_count, o_empty, o_full, o_almost_full, o_overflow, o_underflow);
    end
  endtask

  task automatic test_random();
    logic wr;
    logic rd;
    logic clr;
    logic [7:0] wd;
    int m_cnt;
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 2);
      wd  = 8'($urandom);
      if (rd && q.size() != 0) begin
        n_cmp++; if (o_rdata !== q[0]) begin n_err++; $display("FAIL rnd_sample@%0d: got %h expected %h", n, o_rdata, q[0]); end
      end
      apply(wr, wd, rd, clr, 1'b0);
      m_cnt = q.size();
      n_cmp++; if (o_count !== 3'(m_cnt)) begin n_err++; $display("FAIL rnd_count@%0d: got %0d expected %0d", n, o_count, m_cnt); end
      n_cmp++; if ({o_empty, o_full, o_almost_full} !== {m_cnt == 0, m_cnt == 4, m_cnt >= 3}) begin
        n_err++; $display("FAIL rnd_status@%0d: got %b%b%b expected count %0d", n, o_empty, o_full, o_almost_full, m_cnt);
      end
      n_cmp++; if ({o_overflow, o_underflow} !== {m_ovf, m_udf}) begin
        n_err++; $display("FAIL rnd_flags@%0d: got %b%b expected %b%b", n, o_overflow, o_underflow, m_ovf, m_udf);
      end
      if (m_cnt != 0) begin
        n_cmp++; if (o_rdata !== q[0]) begin n_err++; $display("FAIL rnd_head@%0d: got %h expected %h", n, o_rdata, q[0]); end
      end
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_clear = 1'b0;
    i_wr    = 1'b0;
    i_rd    = 1'b0;
    i_wdata = 8'h00;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_back_to_back_wrap();
    test_clear_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
